// File: rtl/soc_loader_pkg.sv
// rtl/soc_loader_pkg.sv - shared state encoding, command bytes and checksum width for the UART boot loader
package soc_loader_pkg;

  localparam int CKSUM_W = 8;

  localparam logic [7:0] CMD_LOAD = 8'h57;  // 'W'
  localparam logic [7:0] CMD_DUMP = 8'h52;  // 'R'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CNT,
    ST_GET_DATA,
    ST_WRITE,
    ST_SEND_SUM,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND_BYTE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/loader_word_shifter.sv
// rtl/loader_word_shifter.sv - 32-bit little-endian word assemble/serialize register with byte index
module loader_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_in,
  input  logic [7:0]  din,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_out,
  output logic [31:0] word,
  output logic [7:0]  dout,
  output logic [1:0]  idx
);

  // Bytes enter at the top and move down, so after four shifts the first byte sits in bits 7:0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= load_data;
      idx  <= '0;
    end else if (shift_in) begin
      word <= {din, word[31:8]};
      idx  <= idx + 2'd1;
    end else if (shift_out) begin
      word <= {8'h00, word[31:8]};
      idx  <= idx + 2'd1;
    end
  end

  assign dout = word[7:0];

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - byte command engine loading/dumping RAM over UART and gating the CPU reset (option: LOADER_TIMEOUT_EN)
module uart_boot_loader
  import soc_loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_owner,
  output logic              cpu_rst,
  output logic              err
);

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  state_t               state, state_n;
  logic [ADDR_W:0]      addr, cnt, addr_p1;
  logic [CKSUM_W-1:0]   cksum;
  logic                 is_load;
  logic                 err_r;
  logic                 accept, rx_fire, timeout;
  logic                 sh_clear, sh_in, sh_load, sh_out;
  logic                 set_err, clr_err, take_cmd, take_cnt, addr_inc, cksum_clr;
  logic [31:0]          word;
  logic [7:0]           dout;
  logic [1:0]           idx;

  assign addr_p1  = addr + 1'b1;
  assign rx_ready = rst_n & accept;
  assign rx_fire  = rx_valid & rx_ready;

  loader_word_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (sh_clear),
    .shift_in  (sh_in),
    .din       (rx_data),
    .load      (sh_load),
    .load_data (mem_rdata),
    .shift_out (sh_out),
    .word      (word),
    .dout      (dout),
    .idx       (idx)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          waiting;

  assign waiting = (state == ST_GET_CNT) || (state == ST_GET_DATA);
  assign timeout = waiting && !rx_fire && (tcnt == TW'(TIMEOUT - 1));

  // Inter-byte idle counter; restarts on every accepted byte and whenever the loader is not waiting for one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (!waiting || rx_fire) begin
      tcnt <= '0;
    end else if (!timeout) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_timeout_param;
  assign timeout              = 1'b0;
  assign unused_timeout_param = (TIMEOUT != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    sh_clear  = 1'b0;
    sh_in     = 1'b0;
    sh_load   = 1'b0;
    sh_out    = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    take_cmd  = 1'b0;
    take_cnt  = 1'b0;
    addr_inc  = 1'b0;
    cksum_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = 1'b1;
        if (rx_fire) begin
          if (rx_data == CMD_LOAD || rx_data == CMD_DUMP) begin
            clr_err  = 1'b1;
            take_cmd = 1'b1;
            state_n  = ST_GET_CNT;
          end else if (rx_data == CMD_GO) begin
            clr_err = 1'b1;
            state_n = ST_RUN;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_GET_CNT: begin
        accept = 1'b1;
        if (rx_fire) begin
          if (rx_data == 8'h00 || {1'b0, rx_data} > DEPTH_B) begin
            set_err = 1'b1;
            state_n = ST_IDLE;
          end else begin
            take_cnt = 1'b1;
            sh_clear = 1'b1;
            state_n  = is_load ? ST_GET_DATA : ST_RD_REQ;
          end
        end else if (timeout) begin
          set_err = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        accept = 1'b1;
        if (rx_fire) begin
          sh_in = 1'b1;
          if (idx == 2'd3) state_n = ST_WRITE;
        end else if (timeout) begin
          set_err  = 1'b1;
          sh_clear = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        addr_inc = 1'b1;
        state_n  = (addr_p1 == cnt) ? ST_SEND_SUM : ST_GET_DATA;
      end
      ST_SEND_SUM: begin
        if (tx_ready) begin
          cksum_clr = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        sh_load = 1'b1;
        state_n = ST_SEND_BYTE;
      end
      ST_SEND_BYTE: begin
        if (tx_ready) begin
          sh_out = 1'b1;
          if (idx == 2'd3) begin
            addr_inc = 1'b1;
            state_n  = (addr_p1 == cnt) ? ST_IDLE : ST_RD_REQ;
          end
        end
      end
      ST_RUN: begin
        accept = 1'b1;
        if (rx_fire && rx_data == CMD_HALT) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Command flag, word count, address, running checksum and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load <= 1'b0;
      cnt     <= '0;
      addr    <= '0;
      cksum   <= '0;
      err_r   <= 1'b0;
    end else begin
      if (take_cmd) is_load <= (rx_data == CMD_LOAD);
      if (set_err)      err_r <= 1'b1;
      else if (clr_err) err_r <= 1'b0;
      if (take_cnt) begin
        cnt  <= rx_data[ADDR_W:0];
        addr <= '0;
      end else if (addr_inc) begin
        addr <= addr_p1;
      end
      if (take_cnt || cksum_clr) cksum <= '0;
      else if (sh_in)            cksum <= cksum + rx_data;
    end
  end

  assign mem_en    = (state == ST_WRITE) || (state == ST_RD_REQ);
  assign mem_we    = (state == ST_WRITE) ? 4'hF : 4'h0;
  assign mem_addr  = addr[ADDR_W-1:0];
  assign mem_wdata = (state == ST_WRITE) ? word : 32'h0;
  assign tx_valid  = (state == ST_SEND_SUM) || (state == ST_SEND_BYTE);
  assign tx_data   = (state == ST_SEND_SUM)  ? cksum :
                     (state == ST_SEND_BYTE) ? dout  : 8'h00;
  assign mem_owner = (state != ST_RUN);
  assign cpu_rst   = (state != ST_RUN);
  assign err       = err_r;

endmodule
